// File: rtl/dplca_txop_table_if.sv
// Bus between the D-PLCA state diagram and the TXOP claim-table tracker.
// DPLCA_TABLE_STATS_EN adds claim_count and claim_reject.
interface dplca_txop_table_if #(
    parameter int unsigned MAX_NODES = 256,
    parameter int unsigned AGE_CNT_W = 16
);
    logic                         dplca_aging;
    logic                         beacon_det;
    logic                         to_claim;
    logic [7:0]                   cur_id;
    logic [7:0]                   plca_node_count;
    logic [AGE_CNT_W-1:0]         aging_cycles;
    logic [MAX_NODES-1:0]         txop_claim_table;
    logic                         dplca_txop_table_upd;
    logic                         dplca_new_age;
    logic [7:0]                   dplca_txop_id;
    logic [7:0]                   dplca_txop_node_count;
`ifdef DPLCA_TABLE_STATS_EN
    logic [$clog2(MAX_NODES+1)-1:0] claim_count;
    logic                           claim_reject;

    modport master (
        output dplca_aging, beacon_det, to_claim, cur_id, plca_node_count, aging_cycles,
        input  txop_claim_table, dplca_txop_table_upd, dplca_new_age, dplca_txop_id,
        input  dplca_txop_node_count, claim_count, claim_reject
    );
    modport slave (
        input  dplca_aging, beacon_det, to_claim, cur_id, plca_node_count, aging_cycles,
        output txop_claim_table, dplca_txop_table_upd, dplca_new_age, dplca_txop_id,
        output dplca_txop_node_count, claim_count, claim_reject
    );
`else
    modport master (
        output dplca_aging, beacon_det, to_claim, cur_id, plca_node_count, aging_cycles,
        input  txop_claim_table, dplca_txop_table_upd, dplca_new_age, dplca_txop_id,
        input  dplca_txop_node_count
    );
    modport slave (
        input  dplca_aging, beacon_det, to_claim, cur_id, plca_node_count, aging_cycles,
        output txop_claim_table, dplca_txop_table_upd, dplca_new_age, dplca_txop_id,
        output dplca_txop_node_count
    );
`endif
endinterface

// File: rtl/dplca_txop_table.sv
// D-PLCA TXOP claim-table tracker: ages per-TO claims over epochs of PLCA cycles.
// Optional DPLCA_TABLE_STATS_EN adds claim_count (popcount) and sticky claim_reject.
module dplca_txop_table #(
    parameter int unsigned MAX_NODES = 256,
    parameter int unsigned AGE_CNT_W = 16
) (
    input logic               clk,
    input logic               plca_reset,
    dplca_txop_table_if.slave bus
);
    localparam logic [1:0] StIdle       = 2'd0;
    localparam logic [1:0] StWaitBeacon = 2'd1;
    localparam logic [1:0] StRun        = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [MAX_NODES-1:0] work_q, work_d;
    logic [MAX_NODES-1:0] table_q, table_d;
    logic [AGE_CNT_W-1:0] age_cnt_q, age_cnt_d;
    logic                 upd_q, upd_d;
    logic                 new_age_q, new_age_d;
    logic [7:0]           txop_id_q, txop_id_d;
    logic [7:0]           node_count_q, node_count_d;

    logic                 claim_ok;
    logic [MAX_NODES-1:0] claim_mask;
    logic [AGE_CNT_W-1:0] age_thr;
    logic [AGE_CNT_W:0]   age_inc;
    logic                 publish;

    always_comb begin
        claim_ok = bus.to_claim && (bus.cur_id < bus.plca_node_count) &&
                   (32'(bus.cur_id) < MAX_NODES);
        claim_mask = '0;
        if (claim_ok) begin
            claim_mask[bus.cur_id] = 1'b1;
        end
        age_thr = (bus.aging_cycles == '0) ? AGE_CNT_W'(1) : bus.aging_cycles;
        // Extra bit so the compare is exact even when age_cnt is saturated.
        age_inc = {1'b0, age_cnt_q} + (AGE_CNT_W+1)'(1);
        publish = age_inc >= {1'b0, age_thr};
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        table_d      = table_q;
        age_cnt_d    = age_cnt_q;
        upd_d        = 1'b0;
        new_age_d    = new_age_q;
        txop_id_d    = txop_id_q;
        node_count_d = node_count_q;

        case (state_q)
            StIdle: begin
                state_d = StWaitBeacon;
            end
            StWaitBeacon: begin
                if (bus.beacon_det) begin
                    state_d   = StRun;
                    age_cnt_d = '0;
                end
            end
            StRun: begin
                work_d  = work_q | claim_mask;
                table_d = table_q | claim_mask;
                if (claim_ok) begin
                    txop_id_d = bus.cur_id;
                end
                if (bus.beacon_det) begin
                    upd_d        = 1'b1;
                    node_count_d = bus.plca_node_count;
                    if (publish) begin
                        // A claim on the boundary belongs to the epoch that is ending.
                        table_d   = work_q | claim_mask;
                        work_d    = '0;
                        age_cnt_d = '0;
                        new_age_d = 1'b1;
                    end else begin
                        age_cnt_d = (&age_cnt_q) ? age_cnt_q : age_inc[AGE_CNT_W-1:0];
                        new_age_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!bus.dplca_aging || state_q == StIdle) begin
            if (!bus.dplca_aging) begin
                state_d = StIdle;
            end
            work_d       = '0;
            table_d      = '0;
            age_cnt_d    = '0;
            upd_d        = 1'b0;
            new_age_d    = 1'b0;
            txop_id_d    = '0;
            node_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (plca_reset) begin
            state_q      <= StIdle;
            work_q       <= '0;
            table_q      <= '0;
            age_cnt_q    <= '0;
            upd_q        <= 1'b0;
            new_age_q    <= 1'b0;
            txop_id_q    <= '0;
            node_count_q <= '0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            table_q      <= table_d;
            age_cnt_q    <= age_cnt_d;
            upd_q        <= upd_d;
            new_age_q    <= new_age_d;
            txop_id_q    <= txop_id_d;
            node_count_q <= node_count_d;
        end
    end

    assign bus.txop_claim_table      = table_q;
    assign bus.dplca_txop_table_upd  = upd_q;
    assign bus.dplca_new_age         = new_age_q;
    assign bus.dplca_txop_id         = txop_id_q;
    assign bus.dplca_txop_node_count = node_count_q;

`ifdef DPLCA_TABLE_STATS_EN
    localparam int unsigned CntW = $clog2(MAX_NODES+1);

    logic [CntW-1:0] pop;
    logic [CntW-1:0] claim_count_q;
    logic            claim_reject_q, claim_reject_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < MAX_NODES; i++) begin
            pop = pop + CntW'(table_q[i]);
        end
        claim_reject_d = claim_reject_q;
        if (state_q == StRun && bus.to_claim && !claim_ok) begin
            claim_reject_d = 1'b1;
        end
        if (!bus.dplca_aging || state_q == StIdle) begin
            claim_reject_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (plca_reset) begin
            claim_count_q  <= '0;
            claim_reject_q <= 1'b0;
        end else begin
            claim_count_q  <= pop;
            claim_reject_q <= claim_reject_d;
        end
    end

    assign bus.claim_count  = claim_count_q;
    assign bus.claim_reject = claim_reject_q;
`endif
endmodule

// File: tb/tb_dplca_txop_table.sv
// Self-checking bench for dplca_txop_table: directed scenarios plus randomized traffic
// compared each cycle against an epoch-level behavioural model.
module tb_dplca_txop_table;
    logic clk = 1'b0;
    logic plca_reset;
    always #5 clk = ~clk;

    dplca_txop_table_if #(.MAX_NODES(256), .AGE_CNT_W(16)) bus ();

    dplca_txop_table #(.MAX_NODES(256), .AGE_CNT_W(16)) dut (
        .clk        (clk),
        .plca_reset (plca_reset),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model: node has left idle (m_en), has seen its sync beacon (m_sync).
    bit       m_en, m_sync;
    bit       pub[256];
    bit       wrk[256];
    int       m_age;
    bit       m_upd, m_new, m_rej;
    bit [7:0] m_id, m_nc;
    int       m_cnt;

    function automatic int popcnt();
        int c = 0;
        for (int i = 0; i < 256; i++) c += int'(pub[i]);
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) begin
            pub[i] = 1'b0;
            wrk[i] = 1'b0;
        end
        m_age = 0; m_upd = 0; m_new = 0; m_id = 0; m_nc = 0;
    endfunction

    function automatic void model_step(bit rst, bit aging, bit beacon, bit claim,
                                       bit [7:0] id, bit [7:0] nc, bit [15:0] ac);
        int thr;
        bit accept;
        m_cnt = rst ? 0 : popcnt();
        if (rst) begin
            model_clear(); m_en = 0; m_sync = 0; m_rej = 0;
            return;
        end
        if (!aging || !m_en) begin
            m_rej = 0;
        end
        if (!aging) begin
            model_clear(); m_en = 0; m_sync = 0;
        end else if (!m_en) begin
            model_clear(); m_en = 1;
        end else if (!m_sync) begin
            m_upd = 0;
            if (beacon) begin
                m_sync = 1; m_age = 0;
            end
        end else begin
            accept = claim && (id < nc);
            if (claim && !accept) m_rej = 1;
            if (accept) begin
                wrk[id] = 1; pub[id] = 1; m_id = id;
            end
            m_upd = beacon;
            if (beacon) begin
                m_nc = nc;
                thr = (ac == 0) ? 1 : int'(ac);
                m_age = m_age + 1;
                if (m_age >= thr) begin
                    for (int i = 0; i < 256; i++) begin
                        pub[i] = wrk[i];
                        wrk[i] = 0;
                    end
                    m_age = 0; m_new = 1;
                end else begin
                    if (m_age > 65535) m_age = 65535;
                    m_new = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [255:0] et;
        for (int i = 0; i < 256; i++) et[i] = pub[i];
        chk("table", bus.txop_claim_table, et);
        chk("upd", 256'(bus.dplca_txop_table_upd), 256'(m_upd));
        chk("new_age", 256'(bus.dplca_new_age), 256'(m_new));
        chk("txop_id", 256'(bus.dplca_txop_id), 256'(m_id));
        chk("node_count", 256'(bus.dplca_txop_node_count), 256'(m_nc));
`ifdef DPLCA_TABLE_STATS_EN
        chk("claim_count", 256'(bus.claim_count), 256'(m_cnt));
        chk("claim_reject", 256'(bus.claim_reject), 256'(m_rej));
`endif
    endtask

    task automatic step(input bit rst, input bit aging, input bit beacon, input bit claim,
                        input bit [7:0] id, input bit [7:0] nc, input bit [15:0] ac);
        plca_reset           = rst;
        bus.dplca_aging      = aging;
        bus.beacon_det       = beacon;
        bus.to_claim         = claim;
        bus.cur_id           = id;
        bus.plca_node_count  = nc;
        bus.aging_cycles     = ac;
        model_step(rst, aging, beacon, claim, id, nc, ac);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Literal expectations that pin the model independently of it.
    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL lit_%s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_run(input bit [15:0] ac);
        step(1, 0, 0, 0, 0, 8, ac);
        step(1, 0, 0, 0, 0, 8, ac);
        step(0, 1, 0, 0, 0, 8, ac);
        step(0, 1, 1, 0, 0, 8, ac);
    endtask

    initial begin
        // Reset state
        step(1, 1, 1, 1, 3, 8, 4);
        step(1, 1, 0, 0, 0, 8, 4);
        lit("rst_table", int'(|bus.txop_claim_table), 0);
        lit("rst_upd", int'(bus.dplca_txop_table_upd), 0);

        // Claims 3 and 5 then beacon: both bits set, upd one clock, no new epoch
        start_run(10);
        lit("sync_no_upd", int'(bus.dplca_txop_table_upd), 0);
        step(0, 1, 0, 1, 3, 8, 10);
        lit("claim3_immediate", int'(bus.txop_claim_table[3]), 1);
        step(0, 1, 0, 1, 5, 8, 10);
        step(0, 1, 1, 0, 0, 8, 10);
        lit("bit3", int'(bus.txop_claim_table[3]), 1);
        lit("bit5", int'(bus.txop_claim_table[5]), 1);
        lit("upd_pulse", int'(bus.dplca_txop_table_upd), 1);
        lit("new_age0", int'(bus.dplca_new_age), 0);
        step(0, 1, 0, 0, 0, 8, 10);
        lit("upd_drop", int'(bus.dplca_txop_table_upd), 0);

        // aging_cycles=2: claim 7 once, published at first swap, dropped at second
        start_run(2);
        step(0, 1, 0, 1, 7, 8, 2);
        step(0, 1, 1, 0, 0, 8, 2);
        lit("ep_b1_new", int'(bus.dplca_new_age), 0);
        step(0, 1, 1, 0, 0, 8, 2);
        lit("ep_b2_new", int'(bus.dplca_new_age), 1);
        lit("ep_b2_bit7", int'(bus.txop_claim_table[7]), 1);
        step(0, 1, 1, 0, 0, 8, 2);
        lit("ep_b3_bit7", int'(bus.txop_claim_table[7]), 1);
        step(0, 1, 1, 0, 0, 8, 2);
        lit("ep_b4_bit7", int'(bus.txop_claim_table[7]), 0);
        lit("ep_b4_new", int'(bus.dplca_new_age), 1);

        // Out-of-range claim ignored
        step(0, 1, 0, 1, 8, 8, 2);
        lit("reject_bit8", int'(bus.txop_claim_table[8]), 0);
        lit("reject_id", int'(bus.dplca_txop_id), 7);

        // Claim coincident with an epoch-ending beacon lands in the published table
        step(0, 1, 1, 1, 2, 8, 1);
        lit("coinc_bit2", int'(bus.txop_claim_table[2]), 1);
        lit("coinc_new", int'(bus.dplca_new_age), 1);
        lit("coinc_pop", int'($countones(bus.txop_claim_table)), 1);

        // Aging dropped mid-run clears everything; re-enable needs a sync beacon first
        step(0, 0, 1, 1, 4, 8, 1);
        lit("drop_table", int'(|bus.txop_claim_table), 0);
        lit("drop_id", int'(bus.dplca_txop_id), 0);
        step(0, 1, 0, 0, 0, 8, 1);
        step(0, 1, 1, 0, 0, 8, 1);
        lit("reen_b1", int'(bus.dplca_txop_table_upd), 0);
        step(0, 1, 1, 0, 0, 8, 1);
        lit("reen_b2", int'(bus.dplca_txop_table_upd), 1);

        // aging_cycles=0 behaves as 1
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1, 8'(k), 8, 0);
            step(0, 1, 1, 0, 0, 8, 0);
            lit("ac0_new", int'(bus.dplca_new_age), 1);
        end

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit       r, a, b, c;
            bit [7:0] id, nc;
            bit [15:0] ac;
            r  = ($urandom_range(0, 599) == 0);
            a  = ($urandom_range(0, 149) != 0);
            b  = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 2) == 0);
            id = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 47));
            nc = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(8, 40));
            ac = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(0, 40))
                                              : 16'($urandom_range(0, 4));
            step(r, a, b, c, id, nc, ac);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
